// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush controller with deferred branch redirects, stall counters and watchdog
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 'h100,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              exception,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int RW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] TO = RW'(TIMEOUT);
  typedef enum logic {RUN, HOLD} state_t;
  state_t state;
  logic [ADDR_W-1:0] pend_target;
  logic [RW-1:0] run_cnt;
  logic back_busy, defer;
  logic [5:0] stall_vec;
  always_comb begin
    back_busy = stallreq_mem | stallreq_ex;
    stall_vec = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
                stallreq_id ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    defer = !exception && state == RUN && redirect_valid && back_busy;
    flush = rst && (exception || (!back_busy && (state == HOLD || redirect_valid)));
    new_pc = !flush ? '0 : exception ? TRAP_VEC : state == HOLD ? pend_target : redirect_target;
    stall = (!rst || flush) ? 6'b000000 : stall_vec;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      pend_target <= '0;
      run_cnt <= '0;
      stall_cycles <= '0;
      flush_count <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state <= exception ? RUN : defer ? HOLD : (state == HOLD && back_busy) ? HOLD : RUN;
      if (defer) pend_target <= redirect_target;
      run_cnt <= !stall[0] ? '0 : run_cnt == TO ? TO : run_cnt + RW'(1);
      stall_timeout <= stall_timeout || (stall[0] && run_cnt == TO - RW'(1));
      stall_cycles <= stall_cycles + CNT_W'(stall[0]);
      flush_count <= flush_count + CNT_W'(flush);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with directed vectors
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst, stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, redirect_valid, exception;
  logic [31:0] redirect_target, new_pc, stall_cycles, flush_count;
  logic [5:0] stall;
  logic flush, stall_timeout;
  int tests = 0;
  int fails = 0;
  string qn[$];
  logic [103:0] qv[$];
  string mn;
  logic [103:0] me, ma;
  pipe_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .exception(exception), .stall(stall), .flush(flush),
    .new_pc(new_pc), .stall_timeout(stall_timeout), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (qv.size() != 0) begin
      mn = qn.pop_front();
      me = qv.pop_front();
      ma = {stall, flush, new_pc, stall_timeout, stall_cycles, flush_count};
      tests++;
      if (ma !== me) begin
        fails++;
        $display("FAIL %s: got stall=%b flush=%b pc=%h to=%b sc=%0d fc=%0d, expected stall=%b flush=%b pc=%h to=%b sc=%0d fc=%0d",
                 mn, ma[103:98], ma[97], ma[96:65], ma[64], ma[63:32], ma[31:0],
                 me[103:98], me[97], me[96:65], me[64], me[63:32], me[31:0]);
      end
    end
  end
  task automatic s(input string n, input logic r, input logic [3:0] req, input logic rv,
                   input logic [31:0] rt, input logic ex, input logic [5:0] st, input logic fl,
                   input logic [31:0] pc, input logic to, input int sc, input int fc);
    logic [31:0] scv, fcv;
    scv = sc;
    fcv = fc;
    rst = r;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    redirect_valid = rv;
    redirect_target = rt;
    exception = ex;
    qn.push_back(n);
    qv.push_back({st, fl, pc, to, scv, fcv});
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'hf;
    redirect_valid = 1'b1;
    redirect_target = 32'h1234;
    exception = 1'b1;
    @(posedge clk);
    #1;
    s("rst_a",      0, 4'b1111, 1, 32'h1234, 1, 6'b000000, 0, 32'h0,    0, 0, 0);
    s("rst_b",      0, 4'b1111, 1, 32'h1234, 1, 6'b000000, 0, 32'h0,    0, 0, 0);
    s("idle",       1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    0, 0, 0);
    s("id_if_1",    1, 4'b0011, 0, 32'h0,    0, 6'b000111, 0, 32'h0,    0, 0, 0);
    s("id_if_2",    1, 4'b0011, 0, 32'h0,    0, 6'b000111, 0, 32'h0,    0, 1, 0);
    s("mem_all",    1, 4'b1011, 0, 32'h0,    0, 6'b011111, 0, 32'h0,    0, 2, 0);
    s("stall_cnt",  1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    0, 3, 0);
    s("redir_now",  1, 4'b0000, 1, 32'h2000, 0, 6'b000000, 1, 32'h2000, 0, 3, 0);
    s("flush_cnt",  1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    0, 3, 1);
    s("defer_1",    1, 4'b1000, 1, 32'h3000, 0, 6'b011111, 0, 32'h0,    0, 3, 1);
    s("defer_2",    1, 4'b1000, 1, 32'h5555, 0, 6'b011111, 0, 32'h0,    0, 4, 1);
    s("defer_3",    1, 4'b1000, 0, 32'h0,    0, 6'b011111, 0, 32'h0,    0, 5, 1);
    s("defer_go",   1, 4'b0011, 0, 32'h4444, 0, 6'b000000, 1, 32'h3000, 0, 6, 1);
    s("defer_done", 1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    0, 6, 2);
    s("ex_defer",   1, 4'b0100, 1, 32'h3000, 0, 6'b001111, 0, 32'h0,    0, 6, 2);
    s("trap",       1, 4'b0100, 0, 32'h0,    1, 6'b000000, 1, 32'h100,  0, 7, 2);
    s("trap_after", 1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    0, 7, 3);
    s("hold_rst_a", 1, 4'b1000, 1, 32'h6000, 0, 6'b011111, 0, 32'h0,    0, 7, 3);
    s("hold_rst_b", 0, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    0, 8, 3);
    s("hold_lost",  1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    0, 0, 0);
    s("wd_a1",      1, 4'b0001, 0, 32'h0,    0, 6'b000011, 0, 32'h0,    0, 0, 0);
    s("wd_a2",      1, 4'b0001, 0, 32'h0,    0, 6'b000011, 0, 32'h0,    0, 1, 0);
    s("wd_a3",      1, 4'b0001, 0, 32'h0,    0, 6'b000011, 0, 32'h0,    0, 2, 0);
    s("wd_gap",     1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    0, 3, 0);
    s("wd_b1",      1, 4'b0001, 0, 32'h0,    0, 6'b000011, 0, 32'h0,    0, 3, 0);
    s("wd_b2",      1, 4'b0001, 0, 32'h0,    0, 6'b000011, 0, 32'h0,    0, 4, 0);
    s("wd_b3",      1, 4'b0001, 0, 32'h0,    0, 6'b000011, 0, 32'h0,    0, 5, 0);
    s("wd_b4",      1, 4'b0001, 0, 32'h0,    0, 6'b000011, 0, 32'h0,    0, 6, 0);
    s("wd_set",     1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    1, 7, 0);
    s("wd_sticky1", 1, 4'b0001, 0, 32'h0,    0, 6'b000011, 0, 32'h0,    1, 7, 0);
    s("wd_sticky2", 1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    1, 8, 0);
    s("wd_rst",     0, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    1, 8, 0);
    s("wd_clear",   1, 4'b0000, 0, 32'h0,    0, 6'b000000, 0, 32'h0,    0, 0, 0);
    for (int i = 0; i < 10 && qv.size() != 0; i++) @(negedge clk);
    #1;
    if (qv.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, 0 required", qv.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It builds the 6-bit stall vector (bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB) and the flush/redirect pair consumed by the PC register and every inter-stage register. It defers branch redirects that arrive during a back-end stall and applies trap redirects immediately. It also keeps stall/flush performance counters and a stall watchdog.

Parameters:
ADDR_W, 32, PC/target width
TRAP_VEC, 32'h0000_0100, exception redirect address
TIMEOUT, 1024, consecutive stall cycles before stall_timeout sets
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
stallreq_if  in  1  I-cache miss / fetch not ready
stallreq_id  in  1  load-use hazard
stallreq_ex  in  1  multicycle EX op busy
stallreq_mem  in  1  D-cache miss / memory busy
redirect_valid  in  1  EX resolved taken branch/jump
redirect_target  in  ADDR_W  branch/jump target
exception  in  1  MEM-stage trap
stall  out  6  stall vector, 1 = hold stage
flush  out  1  clear all inter-stage registers, load PC from new_pc
new_pc  out  ADDR_W  redirect address, valid when flush=1
stall_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  cycles with stall[0]=1
flush_count  out  CNT_W  cycles with flush=1

Behaviour:
- stall, flush and new_pc are combinational from the inputs and the registered state. Counters, flag and FSM update on posedge clk.
- rst=0 at an edge: state <= RUN, pend_target <= 0, run counter, stall_cycles and flush_count <= 0, stall_timeout <= 0.
- While rst=0: stall=0, flush=0, new_pc=0.
- Stall priority, highest first:
  - stallreq_mem: 6'b011111
  - stallreq_ex: 6'b001111
  - stallreq_id: 6'b000111
  - stallreq_if: 6'b000011
  - none: 6'b000000
- back_busy = stallreq_mem | stallreq_ex.
- FSM states: RUN, HOLD.
- Priority 1, exception=1 (any state): flush=1, new_pc=TRAP_VEC, stall=0. Next state RUN; any pending redirect is discarded.
- Priority 2, RUN with redirect_valid & !back_busy: flush=1, new_pc=redirect_target, stall=0. Stay RUN.
- Priority 2, RUN with redirect_valid & back_busy: flush=0, stall per priority. pend_target <= redirect_target. Next state HOLD.
- Priority 3, HOLD with back_busy: flush=0, stall per priority, redirect_valid ignored, stay HOLD.
- Priority 3, HOLD with !back_busy: flush=1, new_pc=pend_target (not redirect_target), stall=0, next state RUN.
- Otherwise: flush=0, new_pc=0, stall per priority.
- flush=1 always forces stall=0, including when stallreq_if or stallreq_id is high that cycle.
- Watchdog run counter:
  - increments (saturating at TIMEOUT) each cycle stall[0]=1; clears on a cycle with stall[0]=0.
  - stall_timeout sets the edge the counter reaches TIMEOUT, i.e. after TIMEOUT consecutive stalled cycles.
  - stall_timeout clears only on reset.
- stall_cycles += 1 each cycle stall[0]=1; flush_count += 1 each cycle flush=1. Both wrap modulo 2^CNT_W.
- Latency: stall and flush react in the same cycle; a deferred redirect issues in the first cycle back_busy=0.
- Reset mid-HOLD: pending redirect is lost and no flush is produced.

Test Plan:
- rst=0 for 2 cycles with all requests high -> stall=0, flush=0, all counters 0; after release with no requests, stall=6'b000000.
- stallreq_id=1 and stallreq_if=1 together -> stall=6'b000111; then stallreq_mem=1 with the others -> stall=6'b011111; stall_cycles counts exactly the asserted cycles.
- RUN, redirect_valid=1, target=32'h0000_2000, no back stall -> same cycle flush=1, new_pc=32'h2000, stall=0; flush_count=1.
- redirect target=32'h3000 while stallreq_mem=1 for 3 cycles, then mem drops while redirect_target is changed to 32'h4444 -> no flush during the 3 cycles; on the drop cycle flush=1, new_pc=32'h3000.
- In HOLD with pend_target=32'h3000, exception=1 -> flush=1, new_pc=32'h100; the next cycle is RUN with no second flush.
- TIMEOUT=4: stallreq_if held 3 cycles, released 1, held 4 -> stall_timeout stays 0 until after the 4th cycle of the second burst, then stays 1 until rst=0.
